// File: rtl/ob_pkg.sv
// ----------------------------------------------------------------------------
// ob_pkg: shared switch definitions for the output buffer and its arbiter.
//   NIN       number of input buffers competing for one output port
//   DATAW     payload width of a flit
//   PKTW      flit width, {flow[1:0], data[DATAW-1:0]}
//   PTRW      width of the round-robin pointer / input index
//   FLOW_*    flow-field bit positions and flow-code enum
//   state_e   output-buffer FSM states
// ----------------------------------------------------------------------------
package ob_pkg;

    localparam int NIN      = 4;
    localparam int DATAW    = 16;
    localparam int PKTW     = DATAW + 2;
    localparam int PTRW     = $clog2(NIN);

    localparam int FLOW_LSB = DATAW;
    localparam int FLOW_MSB = DATAW + 1;

    typedef enum logic [1:0] {
        FLOW_IDLE = 2'b00,
        FLOW_HEAD = 2'b01,
        FLOW_BODY = 2'b10,
        FLOW_TAIL = 2'b11
    } flow_e;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_XFER = 1'b1
    } state_e;

    // Extract the flow code from a raw flit.
    function automatic flow_e flow_of(input logic [PKTW-1:0] flit);
        return flow_e'(flit[FLOW_MSB:FLOW_LSB]);
    endfunction

endpackage

// File: rtl/ob_if.sv
// ----------------------------------------------------------------------------
// ob_if: crossbar-side bundle of one output port.
//   pkti  head flit of every input FIFO, input i at [i*PKTW +: PKTW]
//   req   per-input request toward this port
//   ack   per-input pop strobe (one-hot or zero)
//   full  downstream cannot take a flit this cycle
//   pkto  registered output flit
//   gnt   one-hot current grant
//   busy  a packet is currently owned
// master: the switch fabric around the buffer; slave: the output buffer.
// ----------------------------------------------------------------------------
interface ob_if;
    import ob_pkg::*;

    logic [NIN*PKTW-1:0] pkti;
    logic [NIN-1:0]      req;
    logic [NIN-1:0]      ack;
    logic                full;
    logic [PKTW-1:0]     pkto;
    logic [NIN-1:0]      gnt;
    logic                busy;

    modport master (
        output pkti, req, full,
        input  ack, pkto, gnt, busy
    );

    modport slave (
        input  pkti, req, full,
        output ack, pkto, gnt, busy
    );

endinterface

// File: rtl/ob_rrarb.sv
// ----------------------------------------------------------------------------
// ob_rrarb: combinational round-robin arbiter (rrarb), reusable per port.
//   req      request vector
//   ptr      index of the most recently served requester
//   gnt_oh   one-hot winner (zero when nothing requests)
//   gnt_idx  binary index of the winner
//   valid    at least one request present
// The search starts at (ptr+1) mod N and wraps, so the last winner has the
// lowest priority.
// ----------------------------------------------------------------------------
module ob_rrarb
    import ob_pkg::*;
#(
    parameter int N = NIN,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt_oh,
    output logic [W-1:0] gnt_idx,
    output logic         valid
);

    logic [W-1:0] cand;

    // NOTE: combinational logic uses blocking '=' so later loop iterations
    // see the updated 'valid' flag within the same evaluation.
    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        valid   = 1'b0;
        cand    = '0;
        for (int k = 1; k <= N; k++) begin
            cand = W'((int'(ptr) + k) % N);
            if (!valid && req[cand]) begin
                gnt_oh[cand] = 1'b1;
                gnt_idx      = cand;
                valid        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ob.sv
// ----------------------------------------------------------------------------
// ob: output buffer for one port of the 4-way switch.
//   clk  system clock, rising edge
//   rst  synchronous, active-high reset
//   bus  ob_if.slave: pkti/req/full in, ack/pkto/gnt/busy out
// ARB picks one requesting input (one cycle, no ack). XFER holds that grant
// until a TAIL flit is accepted, acking each non-idle flit while downstream
// is not full. Accepted flits appear on pkto one cycle after their ack;
// every non-accepting cycle registers an IDLE flit instead.
// ----------------------------------------------------------------------------
module ob
    import ob_pkg::*;
(
    input  logic clk,
    input  logic rst,
    ob_if.slave  bus
);

    state_e              state_q, state_d;
    logic [NIN-1:0]      gnt_q,   gnt_d;
    logic                busy_q,  busy_d;
    logic [PTRW-1:0]     ptr_q,   ptr_d;
    logic [PTRW-1:0]     gidx_q,  gidx_d;
    logic [PKTW-1:0]     pkto_q,  pkto_d;

    logic [PKTW-1:0]     flit;
    logic [NIN-1:0]      ack_c;
    logic                accept;

    logic [NIN-1:0]      arb_oh;
    logic [PTRW-1:0]     arb_idx;
    logic                arb_valid;

    ob_rrarb #(.N(NIN), .W(PTRW)) u_arb (
        .req     (bus.req),
        .ptr     (ptr_q),
        .gnt_oh  (arb_oh),
        .gnt_idx (arb_idx),
        .valid   (arb_valid)
    );

    // Head flit of the granted input.
    always_comb begin
        flit = '0;
        for (int i = 0; i < NIN; i++) begin
            if (gidx_q == PTRW'(i)) begin
                flit = bus.pkti[i*PKTW +: PKTW];
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        busy_d  = busy_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        pkto_d  = '0;           // IDLE flit unless something is accepted
        ack_c   = '0;
        accept  = 1'b0;

        case (state_q)
            ST_ARB: begin
                if (arb_valid) begin
                    state_d = ST_XFER;
                    gnt_d   = arb_oh;
                    gidx_d  = arb_idx;
                    busy_d  = 1'b1;
                end
            end
            ST_XFER: begin
                // ack is masked by rst so the input FIFOs, which reset on
                // the same edge, never see a pop during reset.
                accept = !bus.full && (flow_of(flit) != FLOW_IDLE) && !rst;
                if (accept) begin
                    ack_c[gidx_q] = 1'b1;
                    pkto_d        = flit;
                    if (flow_of(flit) == FLOW_TAIL) begin
                        state_d = ST_ARB;
                        ptr_d   = gidx_q;   // served input drops to lowest priority
                        gnt_d   = '0;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    // NOTE: sequential state uses non-blocking '<=' so all flops update
    // together from values sampled at the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ARB;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= PTRW'(NIN - 1);  // input 0 wins the first arbitration
            gidx_q  <= '0;
            pkto_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            pkto_q  <= pkto_d;
        end
    end

    assign bus.ack  = ack_c;
    assign bus.pkto = pkto_q;
    assign bus.gnt  = gnt_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_ob.sv
// ----------------------------------------------------------------------------
// tb_ob: self-checking bench for the output buffer ob.
// A table of per-cycle records drives rst/req/full/bubbles and holds the
// expected ack/gnt/busy. Input FIFOs are modelled as queues that pop on the
// DUT ack; the flit expected to be accepted is pushed to a scoreboard and
// compared against pkto on the following cycle (IDLE when nothing pending).
// A final hand-written sequence throttles full randomly on a long packet.
// ----------------------------------------------------------------------------
module tb_ob;
    import ob_pkg::*;

    logic clk;
    logic rst;

    ob_if bus();

    ob dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string          tag;
        int             ld;
        logic           rst;
        logic [NIN-1:0] req;
        logic           full;
        logic [NIN-1:0] bub;
        logic [NIN-1:0] e_ack;
        logic [NIN-1:0] e_gnt;
        logic           e_busy;
    } vec_t;

    vec_t            tbl[$];
    logic [PKTW-1:0] fifo[NIN][$];
    logic [PKTW-1:0] sb_q[$];
    logic [PKTW-1:0] exp_q[$];
    logic [NIN-1:0]  ack_s;
    int              n_checks = 0;
    int              n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [PKTW-1:0] fl(input flow_e f, input logic [DATAW-1:0] d);
        return {f, d};
    endfunction

    task automatic add(input string tag, input int ld, input logic r, input logic [NIN-1:0] req,
                       input logic full, input logic [NIN-1:0] bub, input logic [NIN-1:0] e_ack,
                       input logic [NIN-1:0] e_gnt, input logic e_busy);
        vec_t v;
        v.tag = tag; v.ld = ld; v.rst = r; v.req = req; v.full = full; v.bub = bub;
        v.e_ack = e_ack; v.e_gnt = e_gnt; v.e_busy = e_busy;
        tbl.push_back(v);
    endtask

    task automatic load(input int code);
        case (code)
            1: begin
                fifo[2].push_back(fl(FLOW_HEAD, 16'h1111));
                fifo[2].push_back(fl(FLOW_BODY, 16'h2222));
                fifo[2].push_back(fl(FLOW_TAIL, 16'h3333));
            end
            2: begin
                for (int i = 0; i < NIN; i++) begin
                    for (int p = 0; p < 2; p++) begin
                        fifo[i].push_back(fl(FLOW_HEAD, DATAW'(32'h2000 + i*256 + p*16)));
                        fifo[i].push_back(fl(FLOW_TAIL, DATAW'(32'h2001 + i*256 + p*16)));
                    end
                end
            end
            3: begin
                fifo[1].push_back(fl(FLOW_HEAD, 16'h3100));
                fifo[1].push_back(fl(FLOW_BODY, 16'h3101));
                fifo[1].push_back(fl(FLOW_BODY, 16'h3102));
                fifo[1].push_back(fl(FLOW_TAIL, 16'h3103));
            end
            4: begin
                fifo[3].push_back(fl(FLOW_HEAD, 16'h4300));
                fifo[3].push_back(fl(FLOW_BODY, 16'h4301));
                fifo[3].push_back(fl(FLOW_TAIL, 16'h4302));
            end
            5: begin
                fifo[0].push_back(fl(FLOW_HEAD, 16'h5000));
                fifo[0].push_back(fl(FLOW_BODY, 16'h5001));
                fifo[0].push_back(fl(FLOW_TAIL, 16'h5002));
                fifo[2].push_back(fl(FLOW_HEAD, 16'h5200));
                fifo[2].push_back(fl(FLOW_TAIL, 16'h5201));
            end
            6: begin
                fifo[1].push_back(fl(FLOW_HEAD, 16'h6100));
                fifo[1].push_back(fl(FLOW_BODY, 16'h6101));
                fifo[1].push_back(fl(FLOW_BODY, 16'h6102));
                fifo[1].push_back(fl(FLOW_TAIL, 16'h6103));
            end
            7: begin
                fifo[0].push_back(fl(FLOW_HEAD, 16'h7000));
                fifo[0].push_back(fl(FLOW_TAIL, 16'h7001));
                fifo[1].push_back(fl(FLOW_HEAD, 16'h7100));
                fifo[1].push_back(fl(FLOW_TAIL, 16'h7101));
            end
            default: ;
        endcase
    endtask

    task automatic drive_pkti(input logic [NIN-1:0] bub);
        logic [NIN*PKTW-1:0] p;
        p = '0;
        for (int i = 0; i < NIN; i++) begin
            if (fifo[i].size() > 0 && !bub[i]) p[i*PKTW +: PKTW] = fifo[i][0];
        end
        bus.pkti = p;
    endtask

    // Advance past the clock edge; input FIFOs pop on ack or clear on rst.
    task automatic finish_cycle();
        @(posedge clk);
        #1;
        for (int i = 0; i < NIN; i++) begin
            if (rst) fifo[i].delete();
            else if (ack_s[i] && fifo[i].size() > 0) void'(fifo[i].pop_front());
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        string           nm;
        logic [PKTW-1:0] exp_pkto;
        nm = $sformatf("row%0d(%s)", idx, v.tag);
        if (v.ld != 0) load(v.ld);
        rst      = v.rst;
        bus.req  = v.req;
        bus.full = v.full;
        drive_pkti(v.bub);
        @(negedge clk);
        check({nm, " ack"},  32'(bus.ack),  32'(v.e_ack));
        check({nm, " gnt"},  32'(bus.gnt),  32'(v.e_gnt));
        check({nm, " busy"}, 32'(bus.busy), 32'(v.e_busy));
        exp_pkto = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
        check({nm, " pkto"}, 32'(bus.pkto), 32'(exp_pkto));
        for (int i = 0; i < NIN; i++) begin
            if (v.e_ack[i]) sb_q.push_back((fifo[i].size() > 0) ? fifo[i][0] : '0);
        end
        ack_s = bus.ack;
        finish_cycle();
    endtask

    initial begin
        bit done;

        //  tag      ld rst req      full bub      ack      gnt      busy
        // 1: single 3-flit packet from input 2
        add("t1c0",  1, 0, 4'b0100, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        add("t1c1",  0, 0, 4'b0100, 0, 4'b0000, 4'b0100, 4'b0100, 1);
        add("t1c2",  0, 0, 4'b0100, 0, 4'b0000, 4'b0100, 4'b0100, 1);
        add("t1c3",  0, 0, 4'b0000, 0, 4'b0000, 4'b0100, 4'b0100, 1);
        add("t1c4",  0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        add("t1c5",  0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        // 2: all four requesting, 2-flit packets, order 0,1,2,3,0
        add("t2rst", 0, 1, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        add("t2c0",  2, 0, 4'b1111, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        add("t2c1",  0, 0, 4'b1111, 0, 4'b0000, 4'b0001, 4'b0001, 1);
        add("t2c2",  0, 0, 4'b1111, 0, 4'b0000, 4'b0001, 4'b0001, 1);
        add("t2c3",  0, 0, 4'b1111, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        add("t2c4",  0, 0, 4'b1111, 0, 4'b0000, 4'b0010, 4'b0010, 1);
        add("t2c5",  0, 0, 4'b1111, 0, 4'b0000, 4'b0010, 4'b0010, 1);
        add("t2c6",  0, 0, 4'b1111, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        add("t2c7",  0, 0, 4'b1111, 0, 4'b0000, 4'b0100, 4'b0100, 1);
        add("t2c8",  0, 0, 4'b1111, 0, 4'b0000, 4'b0100, 4'b0100, 1);
        add("t2c9",  0, 0, 4'b1111, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        add("t2c10", 0, 0, 4'b1111, 0, 4'b0000, 4'b1000, 4'b1000, 1);
        add("t2c11", 0, 0, 4'b1111, 0, 4'b0000, 4'b1000, 4'b1000, 1);
        add("t2c12", 0, 0, 4'b1111, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        add("t2c13", 0, 0, 4'b1111, 0, 4'b0000, 4'b0001, 4'b0001, 1);
        add("t2c14", 0, 0, 4'b1111, 0, 4'b0000, 4'b0001, 4'b0001, 1);
        add("t2c15", 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        add("t2c16", 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        // 3: input 1 stalled by full for 3 cycles mid-packet
        add("t3rst", 0, 1, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        add("t3c0",  3, 0, 4'b0010, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        add("t3c1",  0, 0, 4'b0010, 0, 4'b0000, 4'b0010, 4'b0010, 1);
        add("t3c2",  0, 0, 4'b0010, 0, 4'b0000, 4'b0010, 4'b0010, 1);
        add("t3c3",  0, 0, 4'b0010, 1, 4'b0000, 4'b0000, 4'b0010, 1);
        add("t3c4",  0, 0, 4'b0010, 1, 4'b0000, 4'b0000, 4'b0010, 1);
        add("t3c5",  0, 0, 4'b0010, 1, 4'b0000, 4'b0000, 4'b0010, 1);
        add("t3c6",  0, 0, 4'b0010, 0, 4'b0000, 4'b0010, 4'b0010, 1);
        add("t3c7",  0, 0, 4'b0000, 0, 4'b0000, 4'b0010, 4'b0010, 1);
        add("t3c8",  0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        add("t3c9",  0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        // 4: input 3 FIFO runs empty for 2 cycles after HEAD
        add("t4rst", 0, 1, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        add("t4c0",  4, 0, 4'b1000, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        add("t4c1",  0, 0, 4'b1000, 0, 4'b0000, 4'b1000, 4'b1000, 1);
        add("t4c2",  0, 0, 4'b1000, 0, 4'b1000, 4'b0000, 4'b1000, 1);
        add("t4c3",  0, 0, 4'b1000, 0, 4'b1000, 4'b0000, 4'b1000, 1);
        add("t4c4",  0, 0, 4'b1000, 0, 4'b0000, 4'b1000, 4'b1000, 1);
        add("t4c5",  0, 0, 4'b0000, 0, 4'b0000, 4'b1000, 4'b1000, 1);
        add("t4c6",  0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        add("t4c7",  0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        // 5: req[0] drops mid-packet while req[2] rises
        add("t5rst", 0, 1, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        add("t5c0",  5, 0, 4'b0001, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        add("t5c1",  0, 0, 4'b0001, 0, 4'b0000, 4'b0001, 4'b0001, 1);
        add("t5c2",  0, 0, 4'b0100, 0, 4'b0000, 4'b0001, 4'b0001, 1);
        add("t5c3",  0, 0, 4'b0100, 0, 4'b0000, 4'b0001, 4'b0001, 1);
        add("t5c4",  0, 0, 4'b0100, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        add("t5c5",  0, 0, 4'b0100, 0, 4'b0000, 4'b0100, 4'b0100, 1);
        add("t5c6",  0, 0, 4'b0000, 0, 4'b0000, 4'b0100, 4'b0100, 1);
        add("t5c7",  0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        add("t5c8",  0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        // 6: rst during BODY of input 1, then 4'b0011 grants input 0 first
        add("t6rst", 0, 1, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        add("t6c0",  6, 0, 4'b0010, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        add("t6c1",  0, 0, 4'b0010, 0, 4'b0000, 4'b0010, 4'b0010, 1);
        add("t6c2",  0, 0, 4'b0010, 0, 4'b0000, 4'b0010, 4'b0010, 1);
        add("t6c3",  0, 1, 4'b0010, 0, 4'b0000, 4'b0000, 4'b0010, 1);
        add("t6c4",  7, 0, 4'b0011, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        add("t6c5",  0, 0, 4'b0011, 0, 4'b0000, 4'b0001, 4'b0001, 1);
        add("t6c6",  0, 0, 4'b0010, 0, 4'b0000, 4'b0001, 4'b0001, 1);
        add("t6c7",  0, 0, 4'b0010, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        add("t6c8",  0, 0, 4'b0010, 0, 4'b0000, 4'b0010, 4'b0010, 1);
        add("t6c9",  0, 0, 4'b0000, 0, 4'b0000, 4'b0010, 4'b0010, 1);
        add("t6c10", 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        add("t6c11", 0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0);

        rst      = 1'b1;
        bus.req  = '0;
        bus.full = 1'b0;
        bus.pkti = '0;
        ack_s    = '0;
        repeat (3) @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // 7: long packet from input 2 under random back-pressure; the
        // expected flit order is queued as the stimulus is loaded.
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            flow_e f;
            logic [PKTW-1:0] x;
            f = (k == 0) ? FLOW_HEAD : ((k == 5) ? FLOW_TAIL : FLOW_BODY);
            x = fl(f, DATAW'(32'h8200 + k));
            fifo[2].push_back(x);
            exp_q.push_back(x);
        end
        bus.req = 4'b0100;
        done = 1'b0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            bus.full = 1'($urandom_range(0, 1));
            drive_pkti('0);
            @(negedge clk);
            if (bus.full) check("t7 ack under full", 32'(bus.ack), 32'h0);
            if (flow_of(bus.pkto) != FLOW_IDLE) begin
                if (exp_q.size() == 0) begin
                    check("t7 extra flit", 32'(bus.pkto), 32'h0);
                end else begin
                    check("t7 flit order", 32'(bus.pkto), 32'(exp_q.pop_front()));
                end
                if (flow_of(bus.pkto) == FLOW_TAIL) begin
                    done = 1'b1;
                    check("t7 busy after tail", 32'(bus.busy), 32'h0);
                end
            end
            ack_s = bus.ack;
            finish_cycle();
        end
        check("t7 tail seen", 32'(done), 32'h1);
        check("t7 flits left", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ob.md
Name: ob

Overview:
- Output buffer for one output port of the 4-way switch; the crossbar-side counterpart of the per-port input buffers.
- Each input buffer raises a request toward this port. This block grants one input at a time using round-robin arbitration.
- It holds the grant for the whole packet, head through tail, and acks each flit it accepts.
- Accepted flits are registered and driven to the port, throttled by the downstream full signal.

Parameters:
- NIN, 4, number of input buffers competing for this port.
- DATAW, 16, payload width per flit.
- PKTW, DATAW+2, flit width: {flow[1:0], data[DATAW-1:0]}.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- pkti  in  NIN*PKTW  head flit of each input FIFO; input i occupies bits [i*PKTW +: PKTW].
- req  in  NIN  req[i] = input i has a packet destined for this port.
- ack  out  NIN  one-hot or zero; ack[i] = flit on pkti slice i is consumed this cycle (input FIFO pops on it).
- full  in  1  downstream cannot accept a flit this cycle.
- pkto  out  PKTW  registered output flit; flow=IDLE when no flit is presented.
- gnt  out  NIN  one-hot current grant; zero when idle.
- busy  out  1  high while a packet is owned.

Behaviour:
- Flow encoding, shared: IDLE=2'b00, HEAD=2'b01, BODY=2'b10, TAIL=2'b11. Every packet is HEAD, then zero or more BODY, then TAIL. Minimum packet length is 2 flits.
- Reset (synchronous, rst=1 at clk edge):
  - state=ARB, gnt=0, ack=0, busy=0.
  - pkto=0, i.e. flow IDLE.
  - rr pointer=NIN-1, so input 0 wins first.
- State ARB:
  - If req≠0, search from (ptr+1) mod NIN upward with wrap-around; the first set bit wins.
  - Registered result: gnt=onehot(winner), busy=1, state→XFER.
  - No ack in ARB; arbitration costs exactly 1 cycle.
  - If req=0, stay in ARB.
- State XFER with granted input g:
  - Flit f = pkti slice g.
  - ack[g] = ~full & (f.flow≠IDLE). This is combinational from current state, full and pkti.
  - On an accepting cycle, pkto←f at the clock edge. Latency from ack to pkto visible is 1 cycle.
  - On a non-accepting cycle, pkto←IDLE flit. A stalled or bubbled input yields an idle output cycle, not a repeated flit.
  - If the accepted flit is TAIL: at the edge, state→ARB, ptr←g, gnt←0, busy←0.
  - The next arbitration occurs in the following cycle, so there is at least one idle pkto cycle between packets.
- req deasserting during XFER is ignored. The grant is released only by TAIL.
- HEAD arriving while in XFER is treated as data: no error detection and no reordering.
- full is sampled each cycle; there is no stall-skid buffering.
- ack never asserts for a non-granted input. ack is 0 in ARB and during reset.
- If rst asserts mid-packet, the packet is abandoned: all state returns to reset values the next edge. Input buffers are reset on the same rst.
- Fairness: after serving g, g has the lowest priority in the next arbitration. With all NIN requesting continuously, the grant order is 0,1,2,3,0,…
- Width rules: ptr is $clog2(NIN) bits and the modular increment wraps. The onehot has NIN bits.

Decomposition:
- Shared package (sw package/header), holding:
  - the flow-code constants IDLE/HEAD/BODY/TAIL;
  - DATAW and PKTW;
  - the flow-field bit positions;
  - NIN;
  - the ARB/XFER state enum typedef.
- One natural sub-module: rrarb. It is a combinational round-robin arbiter (req, ptr → onehot winner, valid) and is reusable by other ports.
- The FSM, flit mux and output register stay in ob.

Test Plan:
1. Reset, then req=4'b0100, input 2 presents HEAD(0x1111), BODY(0x2222), TAIL(0x3333), full=0 -> gnt=4'b0100 on cycle 1; ack[2] on cycles 1,2,3; pkto shows the three flits on cycles 2,3,4; pkto IDLE and busy=0 on cycle 5.
2. req=4'b1111 held, every input sending 2-flit packets -> grants ordered 0,1,2,3,0; each packet occupies ARB(1)+2 XFER cycles; there are never two acks in one cycle.
3. Input 1 granted mid-packet with full=1 for 3 cycles -> ack=0 and pkto=IDLE for those 3 cycles; the same flit is acked on the first cycle full=0; no flit is duplicated or lost.
4. Input 3 granted, its pkti goes IDLE for 2 cycles after HEAD (FIFO empty) -> no ack and pkto IDLE for those 2 cycles; transfer resumes on BODY; the grant is held throughout.
5. Input 0 mid-packet, req[0] drops and req[2] rises -> the grant stays on 0 until TAIL; input 2 is granted in the cycle after TAIL is accepted.
6. rst asserted during BODY of input 1 -> next edge: gnt=0, ack=0, pkto=0, state ARB, ptr=NIN-1; the next request set 4'b0011 grants input 0.
